i_wr_ctrl: RTL
==============

Name: i_wr_ctrl

Overview:
Image write controller: sequences a column counter and a row counter to write one width x height image from a pixel stream into SRAM, row-major. It accepts pixels over a valid/ready handshake and issues one SRAM write per pixel, holding each request until acknowledged. It sits between the pixel producer and the SRAM port of the image write path.

Parameters:
ADDR_W, 24, SRAM word address width
DATA_W, 8, pixel/word data width
DIM_W, 13, width of image dimension and counter fields

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; begins a frame when IDLE
abort  in  1  synchronous frame abort
img_width  in  DIM_W  columns per row, sampled on accepted start
img_height  in  DIM_W  rows per frame, sampled on accepted start
base_addr  in  ADDR_W  address of pixel (0,0), sampled on accepted start
pix_valid  in  1  producer has a pixel
pix_data  in  DATA_W  pixel value
pix_ready  out  1  controller accepts pixel this cycle
sram_wr_en  out  1  write request, held until ack
sram_addr  out  ADDR_W  write address
sram_wdata  out  DATA_W  write data
sram_ack  in  1  SRAM write complete
busy  out  1  frame in progress
done  out  1  one-cycle pulse after last write acked
err_cfg  out  1  one-cycle pulse: start with zero width or height
cur_col  out  DIM_W  current column index
cur_row  out  DIM_W  current row index

Behaviour:
- Reset: state IDLE; pix_ready, sram_wr_en, busy, done, err_cfg = 0; sram_addr, sram_wdata, cur_col, cur_row = 0.
- States: IDLE, WAIT_PIX, WRITE, DONE.
- IDLE: on start with width != 0 and height != 0: latch config, col = row = 0, addr = base_addr, busy = 1, go WAIT_PIX next cycle. If width or height is 0: err_cfg pulses next cycle, stay IDLE, no writes.
- WAIT_PIX: pix_ready = 1 (registered, asserted in the same cycle as the state). On pix_valid & pix_ready: latch pix_data into sram_wdata, go WRITE.
- WRITE: sram_wr_en = 1 with stable sram_addr/sram_wdata until the cycle sram_ack = 1. On ack: addr += 1 (mod 2^ADDR_W); col advances. On col == width-1: col wraps to 0 and row increments. If col == width-1 and row == height-1: go DONE. Otherwise go WAIT_PIX. Peak throughput is one pixel per 2 cycles.
- sram_ack outside WRITE is ignored.
- DONE: done = 1 for exactly one cycle, busy = 0 in the same cycle, then IDLE. cur_col and cur_row hold their last values until the next start.
- start while busy: ignored. start in the DONE cycle: ignored.
- abort (any non-IDLE state): next cycle state = IDLE, sram_wr_en = 0, pix_ready = 0, busy = 0, no done. An in-flight write is dropped. abort has priority over ack.
- rst mid-frame: identical to reset values; takes priority over abort and start.
- Width 1 / height 1 are legal: the frame is 1 pixel, done follows the first ack.

Optional Feature:
I_WR_STRIDE_EN: adds input row_stride [ADDR_W-1:0], sampled on start.
- With the macro: at a row wrap, the next address is row_start_addr + row_stride, and row_start_addr is updated to that value.
- Without the macro: the port is absent and the address is contiguous (+1 every write).

Decomposition:
- Package i_wr_pkg: state enum (IDLE, WAIT_PIX, WRITE, DONE) and the DIM_W / ADDR_W defaults.
- Sub-module img_axis_counter (instantiated twice, for column and row). Ports: clk, clear, count_enable, rollover_val, value, at_last. at_last = (value == rollover_val-1). On count_enable at last, value wraps to 0.

Test Plan:
- Reset, then start with width=4, height=3, base=0x100, ack same cycle as wr_en -> 12 writes at addresses 0x100..0x10B in order with data matching the stream; done pulses once; busy drops in the done cycle.
- width=0, height=5, start -> err_cfg pulses one cycle; sram_wr_en is never asserted; busy stays 0.
- width=1, height=1 -> single write at base; done occurs 1 cycle after the ack.
- Ack delayed 3 cycles; pix_valid toggled randomly -> sram_wr_en, address and data stay stable until the ack; no pixel is lost or duplicated; pix_ready = 0 during WRITE.
- abort asserted at the 5th write of a 4x3 frame, together with ack -> the next cycle is IDLE with wr_en = 0; no done; a new start at base 0x200 restarts at col = 0, row = 0.
- base = 2^24-2, width=4, height=1 -> addresses FFFFFE, FFFFFF, 000000, 000001. With I_WR_STRIDE_EN, width=2, height=2, stride=16, base=0 -> addresses 0, 1, 16, 17.

Source files
------------

// File: rtl/i_wr_pkg.sv
// Shared types and default widths for the image write path.
package i_wr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PIX,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned DIM_W_DEF  = 13;
  localparam int unsigned ADDR_W_DEF = 24;

endpackage

// File: rtl/img_axis_counter.sv
// Wrapping index counter for one image axis; at_last flags value == rollover_val-1.
module img_axis_counter #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] value,
  output logic         at_last
);

  assign at_last = (value == rollover_val - W'(1));

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (count_enable) begin
      value <= at_last ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/i_wr_ctrl.sv
// Image write controller: row-major pixel stream to SRAM writes, one write per pixel.
// Optional per-row address stride enabled by defining I_WR_STRIDE_EN.
module i_wr_ctrl
  import i_wr_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_ack,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic [DIM_W-1:0]  cur_col,
  output logic [DIM_W-1:0]  cur_row
`ifdef I_WR_STRIDE_EN
  ,
  input  logic [ADDR_W-1:0] row_stride
`endif
);

  state_t             state;
  logic [DIM_W-1:0]   width_q;
  logic [DIM_W-1:0]   height_q;
  logic               col_last;
  logic               row_last;
  logic               start_ok;
  logic               wr_step;
  logic               cnt_clear;
`ifdef I_WR_STRIDE_EN
  logic [ADDR_W-1:0]  stride_q;
  logic [ADDR_W-1:0]  row_start;
`endif

  assign start_ok  = (state == IDLE) && start && (img_width != '0) && (img_height != '0);
  // abort drops the in-flight write, so the counters must not see that ack
  assign wr_step   = (state == WRITE) && sram_ack && !abort;
  assign cnt_clear = rst || start_ok;

  img_axis_counter #(.W(DIM_W)) u_col (
    .clk          (clk),
    .clear        (cnt_clear),
    .count_enable (wr_step),
    .rollover_val (width_q),
    .value        (cur_col),
    .at_last      (col_last)
  );

  img_axis_counter #(.W(DIM_W)) u_row (
    .clk          (clk),
    .clear        (cnt_clear),
    .count_enable (wr_step && col_last),
    .rollover_val (height_q),
    .value        (cur_row),
    .at_last      (row_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix_ready  <= 1'b0;
      sram_wr_en <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cfg    <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
`ifdef I_WR_STRIDE_EN
      stride_q   <= '0;
      row_start  <= '0;
`endif
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        sram_wr_en <= 1'b0;
        pix_ready  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              width_q   <= img_width;
              height_q  <= img_height;
              sram_addr <= base_addr;
`ifdef I_WR_STRIDE_EN
              stride_q  <= row_stride;
              row_start <= base_addr;
`endif
              busy      <= 1'b1;
              pix_ready <= 1'b1;
              state     <= WAIT_PIX;
            end else if (start) begin
              err_cfg <= 1'b1;
            end
          end
          WAIT_PIX: begin
            if (pix_valid) begin
              sram_wdata <= pix_data;
              pix_ready  <= 1'b0;
              sram_wr_en <= 1'b1;
              state      <= WRITE;
            end
          end
          WRITE: begin
            if (sram_ack) begin
              sram_wr_en <= 1'b0;
`ifdef I_WR_STRIDE_EN
              if (col_last) begin
                sram_addr <= row_start + stride_q;
                row_start <= row_start + stride_q;
              end else begin
                sram_addr <= sram_addr + ADDR_W'(1);
              end
`else
              sram_addr <= sram_addr + ADDR_W'(1);
`endif
              if (col_last && row_last) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                pix_ready <= 1'b1;
                state     <= WAIT_PIX;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
